// File: rtl/gpio_cfg_rx_pkg.sv
// Shared definitions for the GPIO configuration write receiver:
// GPIO word field positions, configuration region map and region decode.
package gpio_cfg_rx_pkg;

    // GPIO word layout
    localparam int WCLK_BIT = 24;             // host write clock
    localparam int ADDR_LSB = 0;              // address field, bits 15:0
    localparam int DATA_LSB = 16;             // data field, bits 23:16
    localparam int SYNC_W   = WCLK_BIT + 1;   // bits brought into the clk domain

    // Configuration region map
    localparam int MAC_SCALER_BASE = 0;
    localparam int NL_SCALER_BASE  = 256;
    localparam int REGION_SIZE     = 256;

    typedef enum logic [1:0] {
        CFG_MAC      = 2'd0,
        CFG_NL       = 2'd1,
        CFG_UNMAPPED = 2'd2
    } cfg_sel_t;

    // Map a register address onto its configuration region.
    // The MAC region starts at address zero, so only its upper bound is tested.
    function automatic cfg_sel_t cfg_decode(input logic [31:0] addr);
        cfg_sel_t sel;
        if (addr < 32'(MAC_SCALER_BASE + REGION_SIZE)) begin
            sel = CFG_MAC;
        end else if (addr < 32'(NL_SCALER_BASE + REGION_SIZE)) begin
            sel = CFG_NL;
        end else begin
            sel = CFG_UNMAPPED;
        end
        return sel;
    endfunction

endpackage

// File: rtl/gpio_cfg_rx_fifo.sv
// cfg_fifo: synchronous first-word-fall-through FIFO. The head entry is read
// combinationally from storage; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module cfg_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             push_ok,
    output logic             pop_ok
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state storage and pointer update for accepted pushes and pops.
    always_comb begin
        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State registers; reset clears storage so the head reads back as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/gpio_cfg_rx.sv
// gpio_cfg_rx: brings the host GPIO word into the fabric clock domain, turns
// each rising edge of the write-clock bit into one queued {addr, data} write,
// and presents the queue head on a valid/ready port with region decode.
module gpio_cfg_rx
    import gpio_cfg_rx_pkg::*;
#(
    parameter int GPIO_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [1:0]        wr_sel,
    output logic [7:0]        wr_index,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic [15:0]       wr_count
);
    localparam int ENTRY_W = ADDR_W + DATA_W;
    // Write clock resets high so a host holding it high through reset
    // cannot look like a fresh rising edge.
    localparam logic [SYNC_W-1:0] SYNC_RST = {1'b1, {(SYNC_W-1){1'b0}}};

    logic [SYNC_W-1:0]  sync1_q, sync1_d;
    logic [SYNC_W-1:0]  sync2_q, sync2_d;
    logic               prev_q, prev_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        wr_count_q, wr_count_d;

    logic               push_req_s;
    logic [ENTRY_W-1:0] push_entry_s;
    logic [ENTRY_W-1:0] head_entry_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               push_ok_s;
    logic               pop_ok_s;
    logic               pop_req_s;
    logic               drop_s;
    cfg_sel_t           head_sel_s;
    logic               unused_gpio_s;

    // Upper GPIO bits carry nothing for this protocol.
    assign unused_gpio_s = ^gpio_in[GPIO_W-1:SYNC_W];

    assign push_req_s   = sync2_q[WCLK_BIT] & ~prev_q;
    assign push_entry_s = {sync2_q[ADDR_LSB +: ADDR_W], sync2_q[DATA_LSB +: DATA_W]};
    assign pop_req_s    = wr_valid & wr_ready;
    // A push into a full queue with no pop in the same cycle is lost.
    assign drop_s       = push_req_s & fifo_full_s & ~pop_ok_s;

    cfg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_req_s),
        .pop     (pop_req_s),
        .din     (push_entry_s),
        .dout    (head_entry_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .push_ok (push_ok_s),
        .pop_ok  (pop_ok_s)
    );

    assign wr_valid = ~fifo_empty_s;
    assign wr_addr  = head_entry_s[ENTRY_W-1:DATA_W];
    assign wr_data  = head_entry_s[DATA_W-1:0];
    assign wr_sel   = head_sel_s;
    assign wr_index = wr_addr[7:0];
    assign ovf      = ovf_q;
    assign wr_count = wr_count_q;

    // Region decode of the queue head address.
    always_comb begin
        head_sel_s = cfg_decode(32'(wr_addr));
    end

    // Next state for synchronizer, edge history, overflow flag and write count.
    always_comb begin
        sync1_d = gpio_in[SYNC_W-1:0];
        sync2_d = sync1_q;
        prev_d  = sync2_q[WCLK_BIT];
        // A new overflow takes priority over a clear in the same cycle.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (push_ok_s) begin
            wr_count_d = wr_count_q + 16'd1;
        end else begin
            wr_count_d = wr_count_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= SYNC_RST;
            sync2_q    <= SYNC_RST;
            prev_q     <= 1'b1;
            ovf_q      <= 1'b0;
            wr_count_q <= 16'd0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            ovf_q      <= ovf_d;
            wr_count_q <= wr_count_d;
        end
    end

endmodule

// File: doc/gpio_cfg_rx.md
# gpio_cfg_rx

Receiver for the PS-to-PL GPIO configuration write protocol. The host places a 16-bit register address and 8-bit data on a 32-bit GPIO word and then raises a write-clock bit; this block synchronizes that word into the fabric clock domain, detects each write-clock rising edge, and queues one write per edge. Writes are presented on a valid/ready port, address-decoded into configuration regions (MAC input scaler, NL input scaler, unmapped), for the register banks downstream.

## Interface
Parameters:
- GPIO_W, 32, GPIO word width
- ADDR_W, 16, address field width (gpio bits 15:0)
- DATA_W, 8, data field width (gpio bits 23:16)
- FIFO_DEPTH, 4, write queue depth; power of two, ≥2

Ports:
- clk  in  1  fabric clock; one clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- gpio_in  in  GPIO_W  raw GPIO word, asynchronous to clk; bit 24 = write clock
- wr_valid  out  1  queue head valid
- wr_ready  in  1  consumer accepts head when wr_valid & wr_ready
- wr_addr  out  ADDR_W  head address
- wr_data  out  DATA_W  head data
- wr_sel  out  2  region: 0 = MAC scaler (addr 0–255), 1 = NL scaler (256–511), 2 = unmapped (≥512)
- wr_index  out  8  addr[7:0], offset within region
- ovf  out  1  sticky overflow flag
- ovf_clr  in  1  clears ovf
- wr_count  out  16  accepted-into-queue write count, wraps at 65535→0

## Operation
- Synchronizer: two-flop chain on gpio_in bits 24:0 (sync1 → sync2), plus prev register holding the previous sync2[24].
- Edge: push_req = sync2[24] & ~prev. Address and data captured from sync2[15:0] and sync2[23:16] in the same cycle.
- Protocol rule (host side): address/data stable before write clock rises and held until it falls; the block does not check this.
- Queue: first-word-fall-through FIFO of {addr, data}; wr_* outputs reflect the head combinationally from storage; wr_sel/wr_index decoded from the head address.
- Push when push_req and (not full or pop this cycle). Pop when wr_valid & wr_ready.
- Full, push_req, no pop: write dropped, ovf ← 1, wr_count unchanged.
- Full, push_req, pop same cycle: both happen, no overflow, occupancy unchanged.
- Empty: wr_valid = 0, and wr_ready is ignored.
- ovf_clr and a new overflow in the same cycle: ovf stays 1 (set wins).
- wr_count increments on every accepted push.

## Timing
- Reset values: wr_valid 0, ovf 0, wr_count 0, FIFO empty, wr_addr/wr_data/wr_sel/wr_index 0. Synchronizer bit 24 (sync1, sync2) and prev reset to 1. Other synchronizer bits reset to 0.
- Write clock held high through reset therefore produces no write. The first write requires an observed low→high transition.
- Latency: gpio_in[24] rises before edge k; sync1 set at k, sync2 at k+1, FIFO write at edge k+2. wr_valid is high from k+2 when the queue was empty.
- Head pops at the edge where wr_valid & wr_ready. The next entry is visible the following cycle; sustained throughput is 1 pop/cycle.
- Minimum host write-clock high and low time: 3 clk cycles each. Shorter pulses may be missed.
- Reset mid-operation empties the queue. Queued writes are discarded, with no partial outputs.

## Structure
- Shared package additions:
  - region base constants (MAC_SCALER_BASE = 0, NL_SCALER_BASE = 256, region size 256)
  - cfg_sel_t enum {CFG_MAC, CFG_NL, CFG_UNMAPPED}
  - existing gpio field bit positions (write clock 24, addr 15:0, data 23:16)
- Sub-module: cfg_fifo, a parameterized synchronous FWFT FIFO (depth, width, full/empty, simultaneous push/pop). Decoder and synchronizer stay in gpio_cfg_rx.

## Test plan
- Single write: gpio_in = 0x00_2A_0005, then set bit 24 → wr_valid rises 3 edges later with wr_addr 5, wr_data 0x2A, wr_sel 0, wr_index 5. wr_count = 1.
- Region decode: writes to 0x0100, 0x01FF, 0x0200 → wr_sel 1/index 0, 1/index 0xFF, 2/index 0x00.
- Backpressure/overflow: wr_ready = 0, issue 5 writes (data 1..5) → head holds data 1, ovf = 1 after the 5th, wr_count = 4. Then raise wr_ready → data 1..4 drain on consecutive cycles, and wr_valid drops.
- Full with simultaneous pop: fill 4, then raise wr_ready in the cycle the 5th push arrives → no ovf, all 5 delivered in order.
- Reset with write clock high: hold bit 24 = 1, pulse rst → no write. Drop bit 24, then raise it → exactly one write.
- Clear race: ovf = 1, assert ovf_clr in the same cycle as a new overflow → ovf remains 1. ovf_clr alone next cycle → ovf = 0.
